// File: rtl/decomp_word_writer_if.sv
// Bus bundle for decomp_word_writer: transfer control, decompressor word input,
// memory write port and status outputs.
// The checksum signal exists only when DWW_CHECKSUM_EN is defined.
// Modport master drives the requests (decompressor/controller side).
// Modport slave is the writer block itself.
interface decomp_word_writer_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 16
);
    logic              load;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W-1:0] word_count;
    logic              store;
    logic [N-1:0]      data_in;
    logic              mem_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [N-1:0]      mem_data;
    logic              busy;
    logic              done;
    logic              overflow;
`ifdef DWW_CHECKSUM_EN
    logic [N-1:0]      checksum;

    modport master (
        output load, base_addr, word_count, store, data_in, mem_ready,
        input  mem_we, mem_addr, mem_data, busy, done, overflow, checksum
    );

    modport slave (
        input  load, base_addr, word_count, store, data_in, mem_ready,
        output mem_we, mem_addr, mem_data, busy, done, overflow, checksum
    );
`else
    modport master (
        output load, base_addr, word_count, store, data_in, mem_ready,
        input  mem_we, mem_addr, mem_data, busy, done, overflow
    );

    modport slave (
        input  load, base_addr, word_count, store, data_in, mem_ready,
        output mem_we, mem_addr, mem_data, busy, done, overflow
    );
`endif
endinterface

// File: rtl/decomp_word_writer.sv
// decomp_word_writer: buffers decompressed words in a small first-word-fall-through
// FIFO and writes them to consecutive memory addresses over a valid/ready port.
// A transfer is started by load and finishes with a one-cycle done pulse once
// word_count words have been written.
// Optional feature macro: DWW_CHECKSUM_EN adds a running XOR of all written words.
module decomp_word_writer #(
    parameter int N      = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    decomp_word_writer_if.slave   bus
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_nxt;

    // FIFO storage and bookkeeping
    logic [N-1:0]      fifo_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  level;
    logic              fifo_full;
    logic              fifo_empty;

    // Transfer bookkeeping
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] count_q;
    logic [ADDR_W-1:0] accepted;
    logic [ADDR_W-1:0] written;
    logic              overflow_q;

    // Per-cycle decisions from the FSM
    logic              load_go;
    logic              push;
    logic              pop;
    logic              drop;
    logic              mem_we;
    logic              busy;
    logic              done;

    assign fifo_full  = (level == CNT_W'(DEPTH));
    assign fifo_empty = (level == '0);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control: push/pop/drop decisions and status outputs
    always_comb begin
        state_nxt = state;
        load_go   = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        drop      = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                // stores arriving before a transfer is armed are ignored
                if (bus.load) begin
                    load_go   = 1'b1;
                    state_nxt = (bus.word_count == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                mem_we = !fifo_empty;
                pop    = mem_we && bus.mem_ready;
                if (bus.store) begin
                    // a simultaneous pop frees the slot, so a full FIFO can still take the word
                    if (!fifo_full || pop) begin
                        push = 1'b1;
                    end else begin
                        drop = 1'b1;
                    end
                end
                if (push && ((accepted + ADDR_W'(1)) == count_q)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy   = 1'b1;
                mem_we = !fifo_empty;
                pop    = mem_we && bus.mem_ready;
                // all expected words are in; anything further is an upstream error
                if (bus.store) begin
                    drop = 1'b1;
                end
                if (pop && ((written + ADDR_W'(1)) == count_q)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Transfer counters, FIFO pointers/level and the sticky overflow flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            base_q     <= '0;
            count_q    <= '0;
            accepted   <= '0;
            written    <= '0;
            overflow_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
        end else if (load_go) begin
            base_q     <= bus.base_addr;
            count_q    <= bus.word_count;
            accepted   <= '0;
            written    <= '0;
            overflow_q <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
        end else begin
            if (push) begin
                wr_ptr   <= wr_ptr + PTR_W'(1);
                accepted <= accepted + ADDR_W'(1);
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_W'(1);
                written <= written + ADDR_W'(1);
            end
            level <= level + CNT_W'(push) - CNT_W'(pop);
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // FIFO word storage; contents are qualified by level, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.data_in;
        end
    end

    assign bus.mem_we   = mem_we;
    // address wraps modulo 2^ADDR_W through natural truncation
    assign bus.mem_addr = base_q + written;
    // head is only presented while a write is requested, otherwise the bus rests at zero
    assign bus.mem_data = mem_we ? fifo_mem[rd_ptr] : '0;
    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.overflow = overflow_q;

`ifdef DWW_CHECKSUM_EN
    logic [N-1:0] checksum_q;

    // Running XOR of every word that leaves the FIFO; cleared when a transfer is armed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            checksum_q <= '0;
        end else if (load_go) begin
            checksum_q <= '0;
        end else if (pop) begin
            checksum_q <= checksum_q ^ bus.mem_data;
        end
    end

    assign bus.checksum = checksum_q;
`endif

endmodule

// File: doc/decomp_word_writer.md
# decomp_word_writer

Downstream stage of the decompressor. Captures each completed N-bit word presented with `store`, buffers it in a small FIFO and writes it to memory at consecutive addresses through a valid/ready write port. Signals completion after a programmed number of words. It decouples the decompressor, which can emit a word every cycle, from a memory port that may stall.

## Interface
- `N`, 32, word width; must match the decompressor's `N`.
- `DEPTH`, 4, FIFO depth in words; power of two, at least 2.
- `ADDR_W`, 16, width of the memory address and the word counters.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `load` input 1: one-cycle pulse; latches `base_addr` and `word_count` and starts a transfer.
- `base_addr` input ADDR_W: first write address.
- `word_count` input ADDR_W: number of words expected in the transfer.
- `store` input 1: word-valid strobe from the decompressor.
- `data_in` input N: decompressed word, valid when `store` is 1.
- `mem_ready` input 1: memory accepts the current write at this edge.
- `mem_we` output 1: write request valid.
- `mem_addr` output ADDR_W: write address.
- `mem_data` output N: write data.
- `busy` output 1: high in RUN and DRAIN.
- `done` output 1: one-cycle pulse when the last word is written.
- `overflow` output 1: sticky error flag.
- `checksum` output N: present only with `DWW_CHECKSUM_EN`.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - `load` with `word_count`≠0 → RUN. Latches the address pointer, clears the accepted and written counters, and clears `overflow`.
  - `load` with `word_count`=0 → DONE.
  - `store` is ignored.
- RUN, push rule:
  - A `store` is accepted if the FIFO is not full, or if a pop occurs in the same cycle.
  - Each accepted store increments `accepted`.
  - When `accepted` reaches `word_count` → DRAIN.
- Pop rule: `mem_we` = FIFO not empty AND state is RUN or DRAIN. A pop occurs on any edge with `mem_we`=1 and `mem_ready`=1; the pop increments the address pointer and `written`.
- Presentation: `mem_data` is the FIFO head (first-word fall-through). `mem_addr` is `base_addr` + `written`, modulo 2^ADDR_W; the address wraps silently.
- DRAIN: further `store` pulses are dropped and set `overflow`. When `written` reaches `word_count` → DONE.
- DONE: `done`=1 for exactly one cycle, then → IDLE.
- `overflow` is set by either of:
  - `store` while the FIFO is full with no simultaneous pop (the word is dropped);
  - `store` in DRAIN.

  It stays set until the next accepted `load` or reset.
- `load` in RUN, DRAIN or DONE is ignored.
- Reset mid-operation discards FIFO contents and any pending write; state → IDLE.

## Timing
- Reset values:
  - `mem_we`=0, `mem_addr`=0, `mem_data`=0, `busy`=0, `done`=0, `overflow`=0, `checksum`=0.
  - FIFO empty, counters 0.
- Push latency: a store sampled at edge k into an empty FIFO gives `mem_we`=1 with that word after edge k.
- Throughput: one word per cycle sustained while `mem_ready`=1; the FIFO never fills under that condition.
- Write handshake: `mem_we`, `mem_addr` and `mem_data` hold stable until the edge where `mem_ready`=1.
- `done` latency: `done` rises the cycle after the edge that pops the last word. `busy` falls on the same edge.
- Full + push + pop in the same cycle: the push is accepted and the FIFO count is unchanged.

## Configuration
- `DWW_CHECKSUM_EN` defined:
  - `checksum` port exists. On each pop, `checksum` ← `checksum` XOR `mem_data`.
  - Cleared on reset and on an accepted `load`; holds its value after DONE.
- `DWW_CHECKSUM_EN` undefined: no `checksum` port and no checksum logic.

## Test plan
- Load base=0x0100, count=3, `mem_ready`=1; stores of 0xAAAA0001/0xAAAA0002/0xAAAA0003 on consecutive cycles → writes to 0x0100..0x0102 in order, `done` pulse one cycle after the third write, `overflow`=0.
- DEPTH=4, `mem_ready`=0, 5 back-to-back stores → first 4 buffered, 5th dropped, `overflow`=1. Then `mem_ready`=1 → exactly 4 writes, no `done` (count=8).
- FIFO full; store with `mem_ready`=1 in the same cycle → store accepted, FIFO level stays 4, `overflow`=0.
- base=0xFFFE, count=4 → addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- count=0 load → `done` one cycle later, `mem_we` never asserted. Separately, reset low during RUN with 2 words buffered → all outputs 0 immediately, no further writes after release.
- With `DWW_CHECKSUM_EN`, words 0x0F0F0F0F, 0xFFFF0000 → `checksum`=0xF0F00F0F after `done`.
